// File: rtl/traffic_pkg.sv
// Shared encodings for the country-road traffic controller and its loop detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package traffic_pkg;

  // Loop-detector FSM states; also exported on the debug state port.
  typedef enum logic [2:0] {
    DET_IDLE    = 3'd0,
    DET_QUALIFY = 3'd1,
    DET_PRESENT = 3'd2,
    DET_HOLD    = 3'd3,
    DET_FAULT   = 3'd4
  } det_state_e;

  // Lamp codes driven by sig_control.
  typedef enum logic [1:0] {
    LIGHT_RED    = 2'd0,
    LIGHT_YELLOW = 2'd1,
    LIGHT_GREEN  = 2'd2
  } light_e;

  // sig_control state codes.
  typedef enum logic [2:0] {
    CTRL_S0 = 3'd0,
    CTRL_S1 = 3'd1,
    CTRL_S2 = 3'd2,
    CTRL_S3 = 3'd3,
    CTRL_S4 = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/vehicle_detector_if.sv
// Bundle between the loop sensor side and the detector.
// Latency: n/a (wires only).
// Backpressure: none; every signal is a level or a single-cycle pulse.
// Signals: loop_raw (raw sensor), fault_clr (fault acknowledge pulse),
//          X (car-present request), fault (stuck-loop flag), state_o (debug state).
interface vehicle_detector_if;
  logic       loop_raw;
  logic       fault_clr;
  logic       X;
  logic       fault;
  logic [2:0] state_o;

  // master: sensor/bench side, slave: the detector itself.
  modport master (output loop_raw, output fault_clr,
                  input  X, input fault, input state_o);
  modport slave  (input  loop_raw, input fault_clr,
                  output X, output fault, output state_o);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Latency: 2 clock cycles from d to q.
// Backpressure: none.
// Ports: clock, clear_n (async active-low clear), d (async input), q (synchronised output).
module sync_2ff (
  input  logic clock,
  input  logic clear_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/vehicle_detector.sv
// Turns the raw inductive-loop sensor into a clean, hold-extended car-present request X.
// Latency: X rises DEBOUNCE+2 edges after loop_raw is first sampled high; falls HOLD+2 edges after the drop.
// Backpressure: none; a loop occupied for MAX_PRESENT cycles forces FAULT with X low until acknowledged.
// Ports: clock, clear_n (async active-low reset), det (slave side of vehicle_detector_if).
module vehicle_detector
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE    = 4,
  parameter int HOLD        = 8,
  parameter int MAX_PRESENT = 255,
  parameter int CNT_W       = 8
) (
  input  logic                 clock,
  input  logic                 clear_n,
  vehicle_detector_if.slave    det
);

  localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_PRESENT);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C = '0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE_C;
  endfunction

  logic             loop_s;
  det_state_e       state_q, state_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] pres_cnt_q, pres_cnt_d;
  logic [CNT_W-1:0] pres_inc;
  logic             x_q, x_d;
  logic             fault_q, fault_d;

  sync_2ff u_loop_sync (
    .clock   (clock),
    .clear_n (clear_n),
    .d       (det.loop_raw),
    .q       (loop_s)
  );

  // pres_inc is the occupancy count including the current cycle, so FAULT is
  // entered exactly MAX_PRESENT edges after X rose.
  assign pres_inc = sat_inc(pres_cnt_q);

  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    pres_cnt_d = pres_cnt_q;
    case (state_q)
      DET_IDLE: begin
        deb_cnt_d  = ZERO_C;
        hold_cnt_d = ZERO_C;
        pres_cnt_d = ZERO_C;
        if (loop_s) begin
          state_d   = DET_QUALIFY;
          deb_cnt_d = ONE_C;
        end
      end
      DET_QUALIFY: begin
        if (!loop_s) begin
          state_d   = DET_IDLE;
          deb_cnt_d = ZERO_C;
        end else if (deb_cnt_q == DEB_C) begin
          state_d   = DET_PRESENT;
          deb_cnt_d = ZERO_C;
        end else begin
          deb_cnt_d = sat_inc(deb_cnt_q);
        end
      end
      DET_PRESENT: begin
        pres_cnt_d = pres_inc;
        if (pres_inc == MAX_C) begin
          state_d = DET_FAULT;
        end else if (!loop_s) begin
          state_d    = DET_HOLD;
          hold_cnt_d = ONE_C;
        end
      end
      DET_HOLD: begin
        // Occupancy keeps accumulating across flicker, so a chattering loop
        // still trips the stuck-loop check.
        pres_cnt_d = pres_inc;
        if (pres_inc == MAX_C) begin
          state_d    = DET_FAULT;
          hold_cnt_d = ZERO_C;
        end else if (loop_s) begin
          state_d    = DET_PRESENT;
          hold_cnt_d = ZERO_C;
        end else if (hold_cnt_q == HOLD_C) begin
          state_d    = DET_IDLE;
          hold_cnt_d = ZERO_C;
          pres_cnt_d = ZERO_C;
        end else begin
          hold_cnt_d = sat_inc(hold_cnt_q);
        end
      end
      DET_FAULT: begin
        // Only release once the loop has actually gone quiet.
        if (det.fault_clr && !loop_s) begin
          state_d    = DET_IDLE;
          pres_cnt_d = ZERO_C;
        end
      end
      default: begin
        state_d    = DET_IDLE;
        deb_cnt_d  = ZERO_C;
        hold_cnt_d = ZERO_C;
        pres_cnt_d = ZERO_C;
      end
    endcase
    // Outputs decoded from next state so they switch on the same edge as state.
    x_d     = (state_d == DET_PRESENT) || (state_d == DET_HOLD);
    fault_d = (state_d == DET_FAULT);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= DET_IDLE;
      deb_cnt_q  <= ZERO_C;
      hold_cnt_q <= ZERO_C;
      pres_cnt_q <= ZERO_C;
      x_q        <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      pres_cnt_q <= pres_cnt_d;
      x_q        <= x_d;
      fault_q    <= fault_d;
    end
  end

  assign det.X       = x_q;
  assign det.fault   = fault_q;
  assign det.state_o = state_q;

endmodule

// File: tb/tb_vehicle_detector.sv
// Bench for vehicle_detector: directed latency/fault scenarios plus randomized loop traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_vehicle_detector;

  localparam int DEB  = 4;
  localparam int HLD  = 8;
  localparam int MAXP = 20;

  logic clock = 1'b0;
  logic clear_n;

  vehicle_detector_if dif();

  vehicle_detector #(
    .DEBOUNCE    (DEB),
    .HOLD        (HLD),
    .MAX_PRESENT (MAXP),
    .CNT_W       (8)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .det     (dif)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  string phase = "init";

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s.%s: got %0d expected %0d", phase, tag, got, exp);
  endtask

  // Reference model: the loop is seen through a 2-cycle delay; the detector is
  // described by "how long has the loop been high / low / occupied".
  bit m_s1, m_s2;
  bit m_x, m_fault;
  int m_run;   // consecutive qualifying highs while no car is declared
  int m_low;   // consecutive lows while a car is declared
  int m_occ;   // cycles since the car was declared

  function automatic int m_state();
    if (m_fault) return 4;
    if (m_x)     return (m_low > 0) ? 3 : 2;
    return (m_run > 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_x = 0; m_fault = 0;
    m_run = 0; m_low = 0; m_occ = 0;
  endtask

  task automatic model_step(input bit lr, input bit fc);
    bit ls;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = lr;
    if (m_fault) begin
      if (fc && !ls) begin
        m_fault = 0; m_occ = 0; m_run = 0; m_low = 0;
      end
    end else if (m_x) begin
      if (m_occ + 1 == MAXP) begin
        m_fault = 1; m_x = 0; m_low = 0; m_occ = m_occ + 1;
      end else begin
        m_occ = m_occ + 1;
        if (ls) m_low = 0;
        else if (m_low == HLD) begin
          m_x = 0; m_low = 0; m_occ = 0; m_run = 0;
        end else m_low = m_low + 1;
      end
    end else begin
      if (!ls) m_run = 0;
      else if (m_run == DEB) begin
        m_x = 1; m_run = 0; m_occ = 0; m_low = 0;
      end else m_run = m_run + 1;
    end
  endtask

  task automatic cycle(input bit lr, input bit fc);
    dif.loop_raw  = lr;
    dif.fault_clr = fc;
    @(posedge clock);
    model_step(lr, fc);
    #1;
    chk("x",     int'(dif.X),       int'(m_x));
    chk("fault", int'(dif.fault),   int'(m_fault));
    chk("state", int'(dif.state_o), m_state());
  endtask

  // Drive lr until X equals want; n is the number of edges taken (bounded).
  task automatic run_until_x(input bit lr, input bit want, input int limit, output int n);
    n = 0;
    do begin
      cycle(lr, 1'b0);
      n++;
    end while (dif.X !== want && n < limit);
  endtask

  task automatic do_reset();
    #2 clear_n = 1'b0;
    model_reset();
    #1;
    chk("rst_x",     int'(dif.X),       0);
    chk("rst_fault", int'(dif.fault),   0);
    chk("rst_state", int'(dif.state_o), 0);
    @(posedge clock);
    #2 clear_n = 1'b1;
  endtask

  initial begin
    int n;
    int x_seen;
    clear_n       = 1'b0;
    dif.loop_raw  = 1'b0;
    dif.fault_clr = 1'b0;
    model_reset();

    // Reset state
    phase = "reset";
    #1;
    chk("x0",     int'(dif.X),       0);
    chk("fault0", int'(dif.fault),   0);
    chk("state0", int'(dif.state_o), 0);
    @(posedge clock);
    #2 clear_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0);

    // Clean arrival: 7 high edges to raise X, 11 low edges to drop it.
    phase = "arrival";
    run_until_x(1'b1, 1'b1, 40, n);
    chk("rise_edges", n, DEB + 3);
    cycle(1'b1, 1'b0);
    run_until_x(1'b0, 1'b0, 40, n);
    chk("fall_edges", n, HLD + 3);
    repeat (3) cycle(1'b0, 1'b0);

    // Bounce: never qualifies.
    phase = "bounce";
    x_seen = 0;
    for (int i = 0; i < 14; i++) begin
      cycle((i < 3 || (i >= 4 && i < 7)) ? 1'b1 : 1'b0, 1'b0);
      if (dif.X === 1'b1) x_seen = 1;
    end
    chk("x_never", x_seen, 0);
    chk("idle", int'(dif.state_o), 0);

    // Hold re-trigger.
    phase = "retrigger";
    run_until_x(1'b1, 1'b1, 40, n);
    repeat (5) cycle(1'b0, 1'b0);
    chk("in_hold", int'(dif.state_o), 3);
    repeat (3) cycle(1'b1, 1'b0);
    chk("x_kept", int'(dif.X), 1);
    chk("present", int'(dif.state_o), 2);
    repeat (4) cycle(1'b0, 1'b0);
    chk("hold_restart", int'(dif.state_o), 3);

    // Reset mid-PRESENT.
    phase = "mid_reset";
    do_reset();
    repeat (2) cycle(1'b0, 1'b0);
    run_until_x(1'b1, 1'b1, 40, n);
    chk("present", int'(dif.state_o), 2);
    do_reset();
    repeat (4) cycle(1'b0, 1'b0);
    chk("stay_idle", int'(dif.state_o), 0);

    // Stuck loop: FAULT exactly MAXP edges after X rose.
    phase = "stuck";
    run_until_x(1'b1, 1'b1, 40, n);
    n = 0;
    do begin
      cycle(1'b1, 1'b0);
      n++;
    end while (dif.fault !== 1'b1 && n < 60);
    chk("fault_edges", n, MAXP);
    chk("x_forced_low", int'(dif.X), 0);
    cycle(1'b1, 1'b1);
    chk("clr_ignored", int'(dif.fault), 1);
    repeat (2) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    chk("clr_fault", int'(dif.fault), 0);
    chk("clr_state", int'(dif.state_o), 0);
    repeat (2) cycle(1'b0, 1'b0);

    // Chatter: 1 high / 3 low cannot evade the occupancy limit.
    phase = "chatter";
    run_until_x(1'b1, 1'b1, 40, n);
    n = 0;
    do begin
      cycle((n % 4 == 3) ? 1'b1 : 1'b0, 1'b0);
      n++;
    end while (dif.fault !== 1'b1 && n < 80);
    chk("fault_edges", n, MAXP);
    repeat (2) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    chk("clr_state", int'(dif.state_o), 0);

    // Randomized bursty traffic with sporadic acknowledges.
    phase = "random";
    for (int burst = 0; burst < 250; burst++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = (lvl && $urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(1, 12));
      for (int j = 0; j < len; j++)
        cycle(lvl, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
